audio_sample_sequencer: RTL and testbench

- Per-sample controller for the microphone-to-DAC audio path. One sample timer drives each frame: read one 16-bit word from the microphone ADC over SPI, take an 8-bit window with a gain shift and saturation, then write one 16-bit frame to the 8-bit serial DAC.
- Replaces the separate divided-clock domains with one system clock and clock-enable sequencing; SCK, SS, SCLK, SYNC and DATA are all generated as registered outputs.

---
 rtl/audio_sample_sequencer.sv | 170 +++++++++++++++++
 tb/tb_audio_sample_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sequencer.sv
// Per-sample mic-SPI read, gain window with saturation, and serial DAC write on one clock.
// Optional overrun counter enabled by defining SEQ_OVERRUN_CNT_EN.
module audio_sample_sequencer #(
    parameter int         SAMPLE_DIV = 2268,
    parameter int         SCK_HALF   = 8,
    parameter logic [3:0] DAC_CTRL   = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  gain,
    output logic        SCK,
    output logic        SS,
    input  logic        MISO,
    output logic        board_clk,
    output logic        SYNC,
    output logic        DATA,
    output logic [7:0]  sample,
    output logic [15:0] mic_word,
    output logic        sample_valid,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);
    localparam int TW = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {IDLE, MIC, PROC, DAC, DONE} state_t;

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    half_cnt;
    logic [4:0]    edge_cnt;
    logic [14:0]   mic_sr;
    logic [14:0]   dac_sr;
    logic          start, half_done, last_edge;
    logic [15:0]   mic_next;
    logic [2:0]    shamt;
    logic [7:0]    win, next_sample;
    logic          sat;
    logic [15:0]   frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end
    assign tick = (tick_cnt == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)     state_next = MIC;
            MIC:  if (last_edge) state_next = PROC;
            PROC:                state_next = DAC;
            DAC:  if (last_edge) state_next = DONE;
            DONE:                state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Window is mic_word[11-g:4-g]; saturation looks at the g bits above it.
    always_comb begin
        start       = (state == IDLE) && tick && en;
        half_done   = (half_cnt == 8'(SCK_HALF - 1));
        last_edge   = half_done && (edge_cnt == 5'd31);
        mic_next    = {mic_sr, MISO};
        shamt       = 3'd4 - {1'b0, gain};
        win         = 8'(mic_word >> shamt);
        sat         = |(mic_word[11:9] >> (2'd3 - gain));
        next_sample = sat ? 8'hFF : win;
        frame       = {DAC_CTRL, next_sample, 4'b0000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SCK          <= 1'b1;
            SS           <= 1'b1;
            board_clk    <= 1'b1;
            SYNC         <= 1'b1;
            DATA         <= 1'b0;
            sample       <= '0;
            mic_word     <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            half_cnt     <= '0;
            edge_cnt     <= '0;
            mic_sr       <= '0;
            dac_sr       <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        SS       <= 1'b0;
                        busy     <= 1'b1;
                        half_cnt <= '0;
                        edge_cnt <= '0;
                    end
                end
                MIC: begin
                    half_cnt <= half_done ? '0 : half_cnt + 8'd1;
                    if (half_done) begin
                        edge_cnt <= edge_cnt + 5'd1;
                        SCK      <= ~SCK;
                        if (!SCK)
                            mic_sr <= mic_next[14:0];
                    end
                    // The final toggle is a rising edge, so its MISO bit completes the word.
                    if (last_edge) begin
                        SS       <= 1'b1;
                        mic_word <= mic_next;
                    end
                end
                PROC: begin
                    sample   <= next_sample;
                    dac_sr   <= frame[14:0];
                    SYNC     <= 1'b0;
                    DATA     <= frame[15];
                    half_cnt <= '0;
                    edge_cnt <= '0;
                end
                DAC: begin
                    half_cnt <= half_done ? '0 : half_cnt + 8'd1;
                    if (half_done) begin
                        edge_cnt  <= edge_cnt + 5'd1;
                        board_clk <= ~board_clk;
                        if (!board_clk) begin
                            DATA   <= dac_sr[14];
                            dac_sr <= {dac_sr[13:0], 1'b0};
                        end
                    end
                    if (last_edge) begin
                        SYNC <= 1'b1;
                        DATA <= 1'b0;
                    end
                end
                DONE: begin
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_q <= '0;
        else if (tick && busy && (overrun_q != 8'hFF))
            overrun_q <= overrun_q + 8'd1;
    end
    assign overrun_cnt = overrun_q;
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed bench for audio_sample_sequencer: frame timing, gain/saturation, reset abort,
// back-to-back cadence and the optional overrun counter.
module tb_audio_sample_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, en_b = 1'b0, en_o = 1'b0;
    logic [1:0]  gain = 2'd0;
    logic        miso = 1'b0;

    logic        SCK, SS, board_clk, SYNC, DATA, sample_valid, busy;
    logic [7:0]  sample, overrun_cnt;
    logic [15:0] mic_word;

    logic        b_SCK, b_SS, b_board_clk, b_SYNC, b_DATA, b_valid, b_busy;
    logic [7:0]  b_sample, b_ovr;
    logic [15:0] b_mic;

    logic        o_SCK, o_SS, o_board_clk, o_SYNC, o_DATA, o_valid, o_busy;
    logic [7:0]  o_sample, o_ovr;
    logic [15:0] o_mic;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    audio_sample_sequencer #(.SAMPLE_DIV(200), .SCK_HALF(2), .DAC_CTRL(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .gain(gain), .SCK(SCK), .SS(SS), .MISO(miso),
        .board_clk(board_clk), .SYNC(SYNC), .DATA(DATA), .sample(sample), .mic_word(mic_word),
        .sample_valid(sample_valid), .busy(busy), .overrun_cnt(overrun_cnt));

    audio_sample_sequencer #(.SAMPLE_DIV(140), .SCK_HALF(2), .DAC_CTRL(4'b0000)) dut_b2b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .gain(gain), .SCK(b_SCK), .SS(b_SS), .MISO(1'b0),
        .board_clk(b_board_clk), .SYNC(b_SYNC), .DATA(b_DATA), .sample(b_sample), .mic_word(b_mic),
        .sample_valid(b_valid), .busy(b_busy), .overrun_cnt(b_ovr));

    audio_sample_sequencer #(.SAMPLE_DIV(100), .SCK_HALF(2), .DAC_CTRL(4'b0000)) dut_ovr (
        .clk(clk), .rst_n(rst_n), .en(en_o), .gain(gain), .SCK(o_SCK), .SS(o_SS), .MISO(1'b0),
        .board_clk(o_board_clk), .SYNC(o_SYNC), .DATA(o_DATA), .sample(o_sample), .mic_word(o_mic),
        .sample_valid(o_valid), .busy(o_busy), .overrun_cnt(o_ovr));

    task automatic test_reset();
        logic [6:0] got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {SCK, SS, board_clk, SYNC, DATA, sample_valid, busy};
        total++;
        if (got !== 7'b1111000) $display("FAIL reset_ctrl got=%b exp=%b", got, 7'b1111000);
        else pass_cnt++;
        total++;
        if ({sample, mic_word, overrun_cnt} !== 32'h0)
            $display("FAIL reset_data got=%h exp=0", {sample, mic_word, overrun_cnt});
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    // Acts as the microphone (drives MISO after each SCK fall) and records the DAC bits.
    task automatic test_frame(input logic [15:0] word, input logic [1:0] g,
                              input logic [7:0] exp_sample, input string name);
        logic [15:0] exp_frame, cap;
        logic        prev_sck, prev_bclk, seen;
        int          bit_idx, ss_low, sck_rise, busy_cyc, bclk_fall;
        exp_frame = {4'b0000, exp_sample, 4'b0000};
        cap = '0; seen = 1'b0;
        bit_idx = 15; ss_low = 0; sck_rise = 0; busy_cyc = 0; bclk_fall = 0;
        @(negedge clk);
        gain = g; en = 1'b1;
        prev_sck = SCK; prev_bclk = board_clk;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!SS) begin ss_low++; en = 1'b0; end
            if (prev_sck && !SCK && bit_idx >= 0) begin miso = word[bit_idx]; bit_idx--; end
            if (!prev_sck && SCK) sck_rise++;
            if (prev_bclk && !board_clk) begin cap = {cap[14:0], DATA}; bclk_fall++; end
            if (busy) busy_cyc++;
            prev_sck = SCK; prev_bclk = board_clk;
            if (sample_valid) begin seen = 1'b1; break; end
        end
        en = 1'b0;
        total++;
        if (!seen) $display("FAIL %s_timeout got=no sample_valid exp=pulse within 600 cycles", name);
        else pass_cnt++;
        total++;
        if (ss_low !== 64) $display("FAIL %s_ss_low got=%0d exp=64", name, ss_low);
        else pass_cnt++;
        total++;
        if (sck_rise !== 16) $display("FAIL %s_sck_rise got=%0d exp=16", name, sck_rise);
        else pass_cnt++;
        total++;
        if (busy_cyc !== 130) $display("FAIL %s_busy_len got=%0d exp=130", name, busy_cyc);
        else pass_cnt++;
        total++;
        if (mic_word !== word) $display("FAIL %s_mic_word got=%h exp=%h", name, mic_word, word);
        else pass_cnt++;
        total++;
        if (sample !== exp_sample) $display("FAIL %s_sample got=%h exp=%h", name, sample, exp_sample);
        else pass_cnt++;
        total++;
        if (bclk_fall !== 16 || cap !== exp_frame)
            $display("FAIL %s_dac_frame got=%h/%0d exp=%h/16", name, cap, bclk_fall, exp_frame);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({sample_valid, SYNC, DATA, busy} !== 4'b0100)
            $display("FAIL %s_post got=%b exp=0100", name, {sample_valid, SYNC, DATA, busy});
        else pass_cnt++;
    endtask

    task automatic test_disabled();
        int viol;
        viol = 0;
        en = 1'b0;
        for (int c = 0; c < 610; c++) begin
            @(negedge clk);
            if ({SS, SYNC, SCK, board_clk, sample_valid, busy} !== 6'b111100) viol++;
        end
        total++;
        if (viol !== 0) $display("FAIL disabled_idle got=%0d active cycles exp=0", viol);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic got_ss;
        got_ss = 1'b1;
        @(negedge clk);
        gain = 2'd0; en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!SS) begin got_ss = 1'b0; break; end
        end
        en = 1'b0;
        total++;
        if (got_ss !== 1'b0) $display("FAIL midrst_start got=SS high exp=SS low within 300 cycles");
        else pass_cnt++;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({SS, SCK, SYNC, board_clk, busy} !== 5'b11110)
            $display("FAIL midrst_ctrl got=%b exp=11110", {SS, SCK, SYNC, board_clk, busy});
        else pass_cnt++;
        total++;
        if ({sample, mic_word} !== 24'h0) $display("FAIL midrst_data got=%h exp=0", {sample, mic_word});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        test_frame(16'h0A5C, 2'd0, 8'hA5, "after_rst");
    endtask

    task automatic test_back_to_back();
        int pulses, bad_gap, sync_falls, sync_bad, last_t;
        logic prev_sync;
        pulses = 0; bad_gap = 0; sync_falls = 0; sync_bad = 0; last_t = 0;
        @(negedge clk);
        en_b = 1'b1;
        prev_sync = b_SYNC;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (pulses > 0 && prev_sync && !b_SYNC) sync_falls++;
            prev_sync = b_SYNC;
            if (b_valid) begin
                if (!b_SYNC) sync_bad++;
                if (pulses > 0 && (c - last_t) != 140) bad_gap++;
                last_t = c;
                pulses++;
                if (pulses == 6) break;
            end
        end
        en_b = 1'b0;
        total++;
        if (pulses !== 6) $display("FAIL b2b_pulses got=%0d exp=6", pulses);
        else pass_cnt++;
        total++;
        if (bad_gap !== 0) $display("FAIL b2b_period got=%0d bad gaps exp=0", bad_gap);
        else pass_cnt++;
        total++;
        if (sync_falls !== 5 || sync_bad !== 0)
            $display("FAIL b2b_sync got=%0d frames/%0d low exp=5/0", sync_falls, sync_bad);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int frames;
        frames = 0;
        @(negedge clk);
        en_o = 1'b1;
`ifdef SEQ_OVERRUN_CNT_EN
        for (int c = 0; c < 51600; c++) begin
            @(negedge clk);
            if (o_valid) frames++;
        end
        total++;
        if (o_ovr !== 8'hFF) $display("FAIL ovr_saturate got=%h exp=ff", o_ovr);
        else pass_cnt++;
        repeat (400) @(negedge clk);
        total++;
        if (o_ovr !== 8'hFF) $display("FAIL ovr_hold got=%h exp=ff", o_ovr);
        else pass_cnt++;
`else
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (o_valid) frames++;
            if (o_ovr !== 8'h00) break;
        end
        total++;
        if (o_ovr !== 8'h00) $display("FAIL ovr_tied got=%h exp=00", o_ovr);
        else pass_cnt++;
`endif
        total++;
        if (frames < 3) $display("FAIL ovr_frames got=%0d exp>=3", frames);
        else pass_cnt++;
        en_o = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame(16'h0A5C, 2'd0, 8'hA5, "g0");
        test_frame(16'h0A5C, 2'd1, 8'hFF, "g1_sat");
        test_frame(16'h034C, 2'd2, 8'hD3, "g2");
        test_frame(16'h00F0, 2'd3, 8'h78, "g3");
        test_disabled();
        test_reset_mid_frame();
        test_back_to_back();
        test_overrun();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
